// File: rtl/avr_tick_sched_pkg.sv
// Shared definitions for the AVR tick scheduler: register map, FSM states, CTRL bit positions.
package avr_tick_sched_pkg;

  localparam logic [2:0] A_SEL    = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_RELOAD = 3'd2;
  localparam logic [2:0] A_COUNT  = 3'd3;
  localparam logic [2:0] A_PEND   = 3'd4;
  localparam logic [2:0] A_MASK   = 3'd5;
  localparam logic [2:0] A_VEC    = 3'd6;
  localparam logic [2:0] A_STAT   = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  localparam int unsigned CTRL_EN      = 7;
  localparam int unsigned CTRL_ONESHOT = 6;
  localparam int unsigned STAT_LOST    = 7;

endpackage

// File: rtl/avr_tick_sched_prio.sv
// Priority encoder: lowest set bit of req wins; valid flags any request.
module avr_tick_sched_prio #(
  parameter int unsigned NCH = 8
) (
  input  logic [NCH-1:0] req,
  output logic           valid,
  output logic [2:0]     id
);

  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) id = 3'(i);
    end
  end

endmodule

// File: rtl/avr_tick_sched.sv
// Shares one systick pulse among NCH software timers through a single scanning decrementer.
// Optional macro AVR_TICK_SCHED_PRESCALE_EN adds a 4-bit tick prescaler in STAT[3:0].
module avr_tick_sched
  import avr_tick_sched_pkg::*;
#(
  parameter int unsigned NCH = 8,
  parameter int unsigned CW  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       io_re,
  input  logic       io_we,
  input  logic [2:0] io_a,
  input  logic [7:0] io_di,
  output logic [7:0] io_do,
  output logic       irq,
  output logic       busy
);

  state_t          state;
  logic [2:0]      ch, sel;
  logic [NCH-1:0]  en, oneshot, pend, mask;
  logic [CW-1:0]   reload [NCH];
  logic [CW-1:0]   count  [NCH];
  logic            tkq, lost;
  logic [7:0]      vec_q;
  logic            vec_valid;
  logic [2:0]      vec_id;
  logic            wr, tick_in, last, collide, step;
  logic [CW-1:0]   cur, dec;
  logic [3:0]      presc_rd;
  logic [7:0]      rd;

`ifdef AVR_TICK_SCHED_PRESCALE_EN
  logic [3:0] presc, pcnt;
  assign tick_in  = tick & (pcnt == presc);
  assign presc_rd = presc;
`else
  assign tick_in  = tick;
  assign presc_rd = 4'h0;
`endif

  assign wr   = io_we & ~io_re;
  assign busy = (state == S_SCAN);
  assign last = (32'(ch) == NCH - 1);
  assign cur  = count[ch];
  assign dec  = cur - CW'(1);

  // A CPU write to COUNT/CTRL of the channel under the decrementer cancels that step.
  assign collide = wr && (sel == ch) && ((io_a == A_COUNT) || (io_a == A_CTRL));
  assign step    = (state == S_SCAN) && en[ch] && !collide;

  avr_tick_sched_prio #(.NCH(NCH)) u_prio (
    .req   (pend & mask),
    .valid (vec_valid),
    .id    (vec_id)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      ch      <= '0;
      sel     <= '0;
      en      <= '0;
      oneshot <= '0;
      pend    <= '0;
      mask    <= '0;
      tkq     <= 1'b0;
      lost    <= 1'b0;
      vec_q   <= '0;
      irq     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        reload[i] <= '0;
        count[i]  <= '0;
      end
`ifdef AVR_TICK_SCHED_PRESCALE_EN
      presc <= '0;
      pcnt  <= '0;
`endif
    end else begin
      irq   <= |(pend & mask);
      vec_q <= {vec_valid, 4'b0, vec_id};
`ifdef AVR_TICK_SCHED_PRESCALE_EN
      if (tick) pcnt <= (pcnt == presc) ? 4'h0 : pcnt + 4'h1;
`endif

      if (wr) begin
        case (io_a)
          A_SEL:    if (32'(io_di[2:0]) < NCH) sel <= io_di[2:0];
          A_CTRL: begin
            en[sel]      <= io_di[CTRL_EN];
            oneshot[sel] <= io_di[CTRL_ONESHOT];
            if (io_di[CTRL_EN] && !en[sel]) count[sel] <= reload[sel];
          end
          A_RELOAD: reload[sel] <= io_di[CW-1:0];
          A_COUNT:  count[sel]  <= io_di[CW-1:0];
          A_PEND:   pend <= pend & ~io_di[NCH-1:0];
          A_MASK:   mask <= io_di[NCH-1:0];
          A_STAT: begin
            if (io_di[STAT_LOST]) lost <= 1'b0;
`ifdef AVR_TICK_SCHED_PRESCALE_EN
            presc <= io_di[3:0];
            pcnt  <= '0;
`endif
          end
          default: ;
        endcase
      end

      // Hardware sets below are ordered after the w1c writes so the set wins.
      case (state)
        S_IDLE: begin
          if (tick_in || tkq) begin
            state <= S_SCAN;
            ch    <= '0;
            tkq   <= 1'b0;
          end
        end
        S_SCAN: begin
          if (tick_in) begin
            if (tkq) lost <= 1'b1;
            else     tkq  <= 1'b1;
          end
          ch <= ch + 3'd1;
          if (last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (step) begin
        if (cur != '0) begin
          count[ch] <= dec;
        end else begin
          pend[ch] <= 1'b1;
          if (oneshot[ch]) en[ch]    <= 1'b0;
          else             count[ch] <= reload[ch];
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    case (io_a)
      A_SEL:    rd[2:0] = sel;
      A_CTRL: begin
        rd[CTRL_EN]      = en[sel];
        rd[CTRL_ONESHOT] = oneshot[sel];
      end
      A_RELOAD: rd[CW-1:0]  = reload[sel];
      A_COUNT:  rd[CW-1:0]  = count[sel];
      A_PEND:   rd[NCH-1:0] = pend;
      A_MASK:   rd[NCH-1:0] = mask;
      A_VEC:    rd = vec_q;
      A_STAT:   rd = {lost, 3'b0, presc_rd};
      default:  rd = '0;
    endcase
  end

  assign io_do = io_re ? rd : 8'h00;

endmodule

// File: tb/tb_avr_tick_sched.sv
// Directed self-checking bench for avr_tick_sched (NCH=8, CW=8).
module tb_avr_tick_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       io_re = 1'b0;
  logic       io_we = 1'b0;
  logic [2:0] io_a = '0;
  logic [7:0] io_di = '0;
  logic [7:0] io_do;
  logic       irq, busy;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [2:0] SEL = 3'd0, CTRL = 3'd1, RELOAD = 3'd2, COUNT = 3'd3;
  localparam logic [2:0] PEND = 3'd4, MASK = 3'd5, VEC = 3'd6, STAT = 3'd7;

  avr_tick_sched #(.NCH(8), .CW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .io_re (io_re),
    .io_we (io_we),
    .io_a  (io_a),
    .io_di (io_di),
    .io_do (io_do),
    .irq   (irq),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic io_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    io_we = 1'b1; io_a = a; io_di = d;
    @(posedge clk); #1;
    io_we = 1'b0;
  endtask

  task automatic io_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    io_re = 1'b1; io_a = a;
    #1 d = io_do;
    io_re = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    io_read(a, d);
    check(tag, {24'b0, d}, {24'b0, exp});
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("scan_done", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic tick_settle();
    pulse_tick();
    wait_idle();
  endtask

  initial begin
    logic [7:0] d;
    int hits;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_io_do_idle", {24'b0, io_do}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    for (int a = 0; a < 8; a++) rd_chk("rst_reg", 3'(a), 8'h00);

    // Periodic channel 2, RELOAD=3
    io_write(SEL, 8'd2);
    io_write(RELOAD, 8'd3);
    io_write(CTRL, 8'h80);
    io_write(MASK, 8'h04);
    rd_chk("per_count_loaded", COUNT, 8'd3);
    repeat (3) tick_settle();
    rd_chk("per_3tick_pend", PEND, 8'h00);
    rd_chk("per_3tick_count", COUNT, 8'd0);
    tick_settle();
    rd_chk("per_pend", PEND, 8'h04);
    check("per_irq", {31'b0, irq}, 32'd1);
    rd_chk("per_vec", VEC, 8'h82);
    rd_chk("per_count_reload", COUNT, 8'd3);
    io_write(PEND, 8'h04);
    repeat (2) @(posedge clk);
    #1 check("per_irq_clr", {31'b0, irq}, 32'd0);
    rd_chk("per_pend_clr", PEND, 8'h00);
    io_write(CTRL, 8'h00);

    // One-shot ch5 and priority against periodic ch1
    io_write(SEL, 8'd5);
    io_write(RELOAD, 8'd0);
    io_write(CTRL, 8'hC0);
    io_write(SEL, 8'd1);
    io_write(RELOAD, 8'd0);
    io_write(CTRL, 8'h80);
    io_write(MASK, 8'hFF);
    tick_settle();
    rd_chk("os_pend", PEND, 8'h22);
    rd_chk("os_vec", VEC, 8'h81);
    io_write(SEL, 8'd5);
    rd_chk("os_ctrl_en_clr", CTRL, 8'h40);
    io_write(PEND, 8'h02);
    repeat (2) @(posedge clk);
    rd_chk("os_vec_next", VEC, 8'h85);
    check("os_irq", {31'b0, irq}, 32'd1);
    io_write(CTRL, 8'h00);
    io_write(SEL, 8'd1);
    io_write(CTRL, 8'h00);
    io_write(PEND, 8'hFF);
    io_write(MASK, 8'h00);
    rd_chk("os_cleanup", PEND, 8'h00);

    // Back-to-back ticks at edges 0, 3 and 5
    pulse_tick();
    repeat (2) @(posedge clk);
    pulse_tick();
    @(posedge clk);
    pulse_tick();
    repeat (3) @(posedge clk);
    #1 check("b2b_idle_gap", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1 check("b2b_rerun", {31'b0, busy}, 32'd1);
    rd_chk("b2b_lost", STAT, 8'h80);
    wait_idle();
    check("b2b_no_third", {31'b0, busy}, 32'd0);
    io_write(STAT, 8'h80);
    rd_chk("b2b_lost_clr", STAT, 8'h00);

    // Collision: CPU COUNT write on the step cycle of ch0
    io_write(SEL, 8'd0);
    io_write(RELOAD, 8'd5);
    io_write(CTRL, 8'h80);
    pulse_tick();
    io_write(COUNT, 8'd9);
    wait_idle();
    rd_chk("col_count_cpu_wins", COUNT, 8'd9);
    // Collision: PEND set and w1c on the same edge
    io_write(COUNT, 8'd0);
    pulse_tick();
    io_write(PEND, 8'h01);
    wait_idle();
    rd_chk("col_pend_set_wins", PEND, 8'h01);
    rd_chk("col_count_reload", COUNT, 8'd5);
    io_write(PEND, 8'h01);
    rd_chk("col_pend_w1c", PEND, 8'h00);

    // Write with both strobes is ignored
    io_write(MASK, 8'h0F);
    @(negedge clk);
    io_we = 1'b1; io_re = 1'b1; io_a = MASK; io_di = 8'hF0;
    @(posedge clk); #1;
    io_we = 1'b0; io_re = 1'b0;
    rd_chk("rw_both_ignored", MASK, 8'h0F);
    io_write(MASK, 8'h00);

`ifdef AVR_TICK_SCHED_PRESCALE_EN
    io_write(CTRL, 8'h00);
    io_write(RELOAD, 8'd0);
    io_write(CTRL, 8'h80);
    io_write(STAT, 8'h02);
    rd_chk("presc_rd", STAT, 8'h02);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick_settle();
      io_read(PEND, d);
      if (d[0]) begin
        hits++;
        io_write(PEND, 8'h01);
      end
    end
    check("presc_expiries", 32'(hits), 32'd2);
`else
    io_write(STAT, 8'h0F);
    rd_chk("presc_absent", STAT, 8'h00);
    io_write(CTRL, 8'h00);
    io_write(RELOAD, 8'd0);
    io_write(CTRL, 8'h80);
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      tick_settle();
      io_read(PEND, d);
      if (d[0]) begin
        hits++;
        io_write(PEND, 8'h01);
      end
    end
    check("every_tick_expiries", 32'(hits), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
